// File: rtl/encoding_block_mlane.sv
// Multi-lane transmit encoder: gathers per-lane bytes into 66b/132b/bypass symbols and queues
// them in a first-word-fall-through FIFO. Optional popped-symbol counter under `ENC_STATS_EN.
module encoding_block_mlane #(
  parameter int LANES     = 2,
  parameter int SYM_DEPTH = 2
) (
  input  logic                  enc_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            gen_speed,
  input  logic [3:0]            d_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*8-1:0]    lane_tx,
  output logic [LANES*132-1:0]  sym_out,
  output logic                  sym_valid,
  input  logic                  sym_ready,
`ifdef ENC_STATS_EN
  output logic [15:0]           sym_count,
`endif
  output logic                  new_sym
);

  localparam int SW = LANES * 132;
  localparam int PW = $clog2(SYM_DEPTH);

  logic [3:0]    byte_cnt;
  logic [1:0]    mode_reg;
  logic          ctl_reg;
  logic [127:0]  asm_q [LANES];
  logic [SW-1:0] mem   [SYM_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;

  logic [1:0]    cur_mode;
  logic [3:0]    last_idx;
  logic          cur_ctl;
  logic          fifo_full, fifo_empty;
  logic          accept, take, last_byte, push, pop;
  logic [SW-1:0] sym_next;
  logic [127:0]  payload;

  // The first byte of a symbol decides its format; later bytes follow the latched mode.
  always_comb begin
    cur_mode = (byte_cnt == 4'd0) ? gen_speed : mode_reg;
    cur_ctl  = (byte_cnt == 4'd0) ? (d_sel == 4'd8) : ctl_reg;
    case (cur_mode)
      2'd2:    last_idx = 4'd7;
      2'd1:    last_idx = 4'd15;
      default: last_idx = 4'd0;
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign last_byte  = (byte_cnt == last_idx);
  assign in_ready   = !rst && enable && (gen_speed != 2'd3) && !(last_byte && fifo_full);
  assign accept     = in_valid && in_ready;
  assign take       = accept && (d_sel != 4'd9);
  assign push       = take && last_byte;
  assign pop        = sym_valid && sym_ready;
  assign sym_valid  = !fifo_empty;
  assign sym_out    = mem[rd_ptr[PW-1:0]];

  // Completed symbol includes the byte being accepted on this edge.
  always_comb begin
    sym_next = '0;
    payload  = '0;
    for (int l = 0; l < LANES; l++) begin
      payload = asm_q[l];
      payload[{byte_cnt, 3'b000} +: 8] = lane_tx[l*8 +: 8];
      case (cur_mode)
        2'd2:    sym_next[l*132 +: 132] = {66'b0, payload[63:0], cur_ctl ? 2'b10 : 2'b01};
        2'd1:    sym_next[l*132 +: 132] = {payload, cur_ctl ? 4'b0101 : 4'b1010};
        default: sym_next[l*132 +: 132] = {124'b0, lane_tx[l*8 +: 8]};
      endcase
    end
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      mode_reg <= '0;
      ctl_reg  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      new_sym  <= 1'b0;
      for (int l = 0; l < LANES; l++) asm_q[l] <= '0;
    end else if (!enable) begin
      byte_cnt <= '0;
      mode_reg <= '0;
      ctl_reg  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      new_sym  <= 1'b0;
      for (int l = 0; l < LANES; l++) asm_q[l] <= '0;
    end else begin
      new_sym <= push;
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (take) begin
        if (byte_cnt == 4'd0) begin
          mode_reg <= gen_speed;
          ctl_reg  <= (d_sel == 4'd8);
        end
        byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
        for (int l = 0; l < LANES; l++) asm_q[l][{byte_cnt, 3'b000} +: 8] <= lane_tx[l*8 +: 8];
      end
    end
  end

  // Storage is zeroed on reset so the head reads as zero before the first push.
  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYM_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[PW-1:0]] <= sym_next;
    end
  end

`ifdef ENC_STATS_EN
  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst)          sym_count <= '0;
    else if (!enable) sym_count <= '0;
    else if (pop)     sym_count <= sym_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_encoding_block_mlane.sv
// Randomized bench for encoding_block_mlane against a queue-based reference model,
// with directed passes for the main symbol formats, backpressure, flush and reset.
module tb_encoding_block_mlane;
  localparam int LANES     = 2;
  localparam int SYM_DEPTH = 2;
  localparam int SW        = LANES * 132;

  logic                 enc_clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [1:0]           gen_speed;
  logic [3:0]           d_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*8-1:0]   lane_tx;
  logic [SW-1:0]        sym_out;
  logic                 sym_valid;
  logic                 sym_ready;
  logic                 new_sym;
`ifdef ENC_STATS_EN
  logic [15:0]          sym_count;
`endif

  encoding_block_mlane #(.LANES(LANES), .SYM_DEPTH(SYM_DEPTH)) dut (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .enable    (enable),
    .gen_speed (gen_speed),
    .d_sel     (d_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane_tx   (lane_tx),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
`ifdef ENC_STATS_EN
    .sym_count (sym_count),
`endif
    .new_sym   (new_sym)
  );

  always #5 enc_clk = ~enc_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [SW-1:0] fifo_q [$];
  logic [7:0]    lane_b [LANES][16];
  int            nbytes;
  int            m_mode;
  bit            m_ctl;
  bit            exp_new;
  int            pop_cnt;

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sym_len(input int mode);
    case (mode)
      2: return 8;
      1: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic model_ready();
    int n;
    if (rst || !enable || gen_speed == 2'd3) return 1'b0;
    n = sym_len((nbytes == 0) ? int'(gen_speed) : m_mode);
    return !((nbytes == n - 1) && (fifo_q.size() == SYM_DEPTH));
  endfunction

  task automatic model_clear();
    fifo_q.delete();
    nbytes  = 0;
    m_mode  = 0;
    m_ctl   = 0;
    exp_new = 0;
    pop_cnt = 0;
  endtask

  function automatic logic [SW-1:0] build_sym();
    logic [SW-1:0]  s;
    logic [127:0]   pl;
    s = '0;
    for (int l = 0; l < LANES; l++) begin
      pl = '0;
      for (int k = 0; k < nbytes; k++) pl[k*8 +: 8] = lane_b[l][k];
      if (m_mode == 2)      s[l*132 +: 132] = {66'b0, pl[63:0], m_ctl ? 2'b10 : 2'b01};
      else if (m_mode == 1) s[l*132 +: 132] = {pl, m_ctl ? 4'b0101 : 4'b1010};
      else                  s[l*132 +: 132] = {124'b0, pl[7:0]};
    end
    return s;
  endfunction

  // One clock: check the state left by the previous edge, drive inputs, predict the coming edge.
  task automatic step(input logic en, input logic [1:0] gs, input logic [3:0] ds,
                      input logic iv, input logic [LANES*8-1:0] lt, input logic sr);
    logic rdy;
    bit   pushed;
    @(negedge enc_clk);
    chk("sym_valid", SW'(sym_valid), SW'(fifo_q.size() != 0));
    if (fifo_q.size() != 0) chk("sym_out", sym_out, fifo_q[0]);
    chk("new_sym", SW'(new_sym), SW'(exp_new));
`ifdef ENC_STATS_EN
    chk("sym_count", SW'(sym_count), SW'(pop_cnt[15:0]));
`endif
    enable = en; gen_speed = gs; d_sel = ds; in_valid = iv; lane_tx = lt; sym_ready = sr;
    #1;
    rdy = model_ready();
    chk("in_ready", SW'(in_ready), SW'(rdy));
    pushed = 0;
    if (!en) begin
      model_clear();
    end else begin
      if (fifo_q.size() != 0 && sr) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      if (iv && rdy && ds != 4'd9) begin
        if (nbytes == 0) begin
          m_mode = int'(gs);
          m_ctl  = (ds == 4'd8);
        end
        for (int l = 0; l < LANES; l++) lane_b[l][nbytes] = lt[l*8 +: 8];
        nbytes++;
        if (nbytes == sym_len(m_mode)) begin
          fifo_q.push_back(build_sym());
          nbytes = 0;
          pushed = 1;
        end
      end
      exp_new = pushed;
    end
  endtask

  task automatic do_reset();
    @(negedge enc_clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", SW'(sym_valid), '0);
    chk("rst_new", SW'(new_sym), '0);
    chk("rst_ready", SW'(in_ready), '0);
    chk("rst_out", sym_out, '0);
    model_clear();
    @(posedge enc_clk);
    #2 rst = 1'b0;
  endtask

  function automatic logic [LANES*8-1:0] pair(input logic [7:0] b1, input logic [7:0] b0);
    return {b1, b0};
  endfunction

  logic [SW-1:0] lit;
  logic [1:0]    gs_r;
  logic          sr_hi;
  logic [LANES*8-1:0] lt_r;

  initial begin
    rst = 1'b1; enable = 1'b1; gen_speed = 2'd2; d_sel = 4'd0;
    in_valid = 1'b0; lane_tx = '0; sym_ready = 1'b0;
    model_clear();
    #3;
    chk("reset_ready", SW'(in_ready), '0);
    chk("reset_valid", SW'(sym_valid), '0);
    chk("reset_out", sym_out, '0);
    chk("reset_new", SW'(new_sym), '0);
`ifdef ENC_STATS_EN
    chk("reset_count", SW'(sym_count), '0);
`endif
    #10 rst = 1'b0;

    // 64b/66b data
    for (int k = 0; k < 8; k++) step(1, 2, 0, 1, pair(8'(8'h10 + k), 8'(k)), 1);
    @(posedge enc_clk); #1;
    lit = {66'b0, 64'h1716151413121110, 2'b01, 66'b0, 64'h0706050403020100, 2'b01};
    chk("g2_literal", sym_out, lit);
    chk("g2_new", SW'(new_sym), SW'(1'b1));

    // 128b/132b control
    for (int k = 0; k < 16; k++)
      step(1, 1, (k == 0) ? 4'd8 : 4'd0, 1, pair(8'(8'hB0 + k), 8'(8'hA0 + k)), 1);
    @(posedge enc_clk); #1;
    chk("g3_literal", sym_out[131:0], {124'b0, 8'h00} | {128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 4'b0101});

    // backpressure: three symbols into a two-deep FIFO
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 8; k++) step(1, 2, 0, 1, pair(8'(s*16 + k), 8'(s*16 + k + 8'h80)), 0);
    @(posedge enc_clk); #1;
    chk("bp_full_ready", SW'(in_ready), '0);
    for (int k = 0; k < 6; k++) step(1, 2, 0, 1, pair(8'h27, 8'hA7), 1);
    for (int k = 0; k < 4; k++) step(1, 2, 0, 0, '0, 1);

    // idle bytes and mode change at byte 3
    for (int k = 0; k < 3; k++) step(1, 2, 0, 1, pair(8'(8'h40 + k), 8'(8'h50 + k)), 1);
    step(1, 2, 9, 1, pair(8'hEE, 8'hEE), 1);
    step(1, 1, 0, 1, pair(8'h43, 8'h53), 1);
    step(1, 1, 9, 1, pair(8'hEF, 8'hEF), 1);
    for (int k = 4; k < 8; k++) step(1, 1, 0, 1, pair(8'(8'h40 + k), 8'(8'h50 + k)), 1);
    for (int k = 0; k < 16; k++) step(1, 1, 0, 1, pair(8'(8'h60 + k), 8'(8'h70 + k)), 1);

    // flush at byte 5
    for (int k = 0; k < 5; k++) step(1, 2, 0, 1, pair(8'(8'h90 + k), 8'(8'h98 + k)), 1);
    step(0, 2, 0, 1, pair(8'h95, 8'h9D), 1);
    for (int k = 0; k < 8; k++) step(1, 2, 0, 1, pair(8'(8'hC0 + k), 8'(8'hD0 + k)), 1);

    // reset with one queued symbol and a partial one
    for (int k = 0; k < 11; k++) step(1, 2, 0, 1, pair(8'(8'h30 + k), 8'(8'h20 + k)), 0);
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 2, 0, 1, pair(8'(8'hE0 + k), 8'(8'hF0 + k)), 1);

    // bypass
    step(1, 0, 0, 1, pair(8'h5A, 8'h5A), 1);
    step(1, 0, 0, 1, pair(8'hC3, 8'hC3), 1);
    @(posedge enc_clk); #1;
    chk("byp_second", sym_out[131:0], 132'hC3);
    chk("byp_new", SW'(new_sym), SW'(1'b1));
    step(1, 0, 0, 0, '0, 1);
    step(1, 0, 0, 0, '0, 1);

    // randomized traffic
    gs_r  = 2'd2;
    sr_hi = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2200) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 39) == 0) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3: gs_r = 2'd2;
            4, 5, 6, 7: gs_r = 2'd1;
            8:          gs_r = 2'd0;
            default:    gs_r = 2'd3;
          endcase
        end
        if ($urandom_range(0, 29) == 0) sr_hi = ~sr_hi;
        for (int l = 0; l < LANES; l++) lt_r[l*8 +: 8] = 8'($urandom);
        step($urandom_range(0, 99) != 0, gs_r, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, lt_r,
             sr_hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end
    end
    step(1, 2, 0, 0, '0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/encoding_block_mlane.md
# encoding_block_mlane

Parametrised multi-lane successor to the two-lane transmit encoder. It gathers byte-serial per-lane data into 64b/66b (Gen2) or 128b/132b (Gen3) symbols, or passes single bytes through in bypass (Gen4 byte) mode. Completed symbols go into a small first-word-fall-through symbol FIFO with a valid/ready handshake toward the serialiser, so the serialiser can stall without losing data. It sits between the lane-distribution stage and the per-lane serialisers of the USB4 logical-layer transmit path.

## Interface
- LANES, 2, number of lanes encoded in lock-step (1..4)
- SYM_DEPTH, 2, symbol FIFO depth in symbols (power of two, 2..8)
- enc_clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  block enable; low = synchronous flush
- gen_speed  in  2  2 = 64b/66b (8 bytes), 1 = 128b/132b (16 bytes), 0 = bypass (1 byte), 3 = reserved (no byte accepted)
- d_sel  in  4  type of the current byte: 8 = ordered-set/control symbol, 9 = idle byte (discarded), other = data
- in_valid  in  1  lane_tx holds a byte for every lane
- in_ready  out  1  block can accept the byte
- lane_tx  in  LANES*8  lane i byte at [i*8 +: 8]
- sym_out  out  LANES*132  lane i symbol at [i*132 +: 132]; head of FIFO
- sym_valid  out  1  FIFO not empty
- sym_ready  in  1  serialiser pops the head
- new_sym  out  1  one-cycle pulse: a symbol was pushed into the FIFO last edge
- sym_count  out  16  only with ENC_STATS_EN (see Configuration)

## Operation
- Accept: a byte is accepted on an edge where in_valid && in_ready.
- Idle bytes: an accepted byte with d_sel==9 is dropped. byte_cnt does not change.
- Assembly:
  - byte_cnt counts 0..N-1, with N=8/16/1 for gen_speed 2/1/0.
  - An accepted byte is written into byte position byte_cnt of each lane's assembly register; byte 0 sits at payload bits [7:0].
- Mode and header latch:
  - mode_reg latches gen_speed when byte_cnt==0 and a byte is accepted.
  - ctl_reg latches (d_sel==8) on that same byte.
  - A change of gen_speed mid-symbol has no effect until the next symbol boundary.
- Completion: when byte N-1 is accepted, the symbol is pushed and byte_cnt returns to 0. Symbol format:
  - 64b/66b: {66'b0, payload[63:0], hdr}. hdr = 2'b10 if control, else 2'b01.
  - 128b/132b: {payload[127:0], hdr}. hdr = 4'b0101 if control, else 4'b1010.
  - Bypass: {124'b0, byte}. No header.
- in_ready = enable && gen_speed!=3 && !(byte_cnt==N-1 && fifo_full).
  - With gen_speed 3, the block holds in_ready low.
  - in_ready does not depend on sym_ready in the same cycle. A full FIFO blocks only the completing byte; earlier bytes are still accepted.
- FIFO:
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pop happens on sym_valid && sym_ready.
  - sym_out holds its value while sym_valid && !sym_ready.
- enable low: on the next edge the block clears byte_cnt, the assembly registers, mode_reg, ctl_reg and the FIFO pointers. sym_valid falls.
- Reset mid-operation: the same clearing, applied asynchronously. A partial symbol is discarded and never emitted.

## Timing
- Reset values:
  - in_ready = 0 (it follows enable after reset)
  - sym_valid = 0
  - sym_out = 0
  - new_sym = 0
  - sym_count = 0
- Latency: last byte accepted at edge t gives sym_valid=1 and new_sym=1 after edge t, when the FIFO was empty. With a non-empty FIFO the symbol is queued behind the older ones.
- Throughput: one symbol every N accepted bytes. With sym_ready held high, there are no bubbles.
- new_sym: high for exactly one cycle per pushed symbol, including bypass symbols, so it can be high every cycle in bypass mode.
- sym_out and sym_valid are driven from registers and FIFO storage. There is no combinational path from the inputs to them.

## Configuration
- ENC_STATS_EN:
  - Defined: adds output sym_count[15:0], a count of popped symbols. It wraps from 0xFFFF to 0, and is cleared by rst or by enable low.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- 64b/66b data, LANES=2:
  - Stimulus: gen_speed=2, d_sel=0, eight bytes 0x00..0x07 on lane 0 and 0x10..0x17 on lane 1, sym_ready=1.
  - Expected: lane 0 symbol[65:0] = {64'h0706050403020100, 2'b01}; lane 1 symbol = {64'h1716151413121110, 2'b01}; bits 131:66 = 0; one new_sym pulse.
- 128b/132b control:
  - Stimulus: gen_speed=1, d_sel=8 on byte 0 and 0 afterwards, bytes 0xA0..0xAF.
  - Expected: symbol = {128'hAFAE…A1A0, 4'b0101}.
- Backpressure:
  - Stimulus: SYM_DEPTH=2, sym_ready=0, three 64b/66b symbols offered.
  - Expected: two symbols are queued; in_ready drops at byte 7 of the third symbol; raising sym_ready pops them in order with no loss or duplication.
- Idle and mode change:
  - Stimulus: insert d_sel=9 bytes mid-symbol, and switch gen_speed 2→1 at byte 3.
  - Expected: idle bytes are absent from the payload; the current symbol completes as 66b; the next symbol is 132b.
- Flush and reset:
  - Stimulus: drop enable at byte 5 of a symbol; separately assert rst mid-symbol with the FIFO holding one entry.
  - Expected: sym_valid=0 afterwards; the next symbol is built from fresh bytes only.
- Bypass with stats (ENC_STATS_EN defined):
  - Stimulus: gen_speed=0, bytes 0x5A then 0xC3, sym_ready=1.
  - Expected: sym_out = 132'h5A then 132'hC3 on consecutive cycles; new_sym high on both cycles; sym_count = 2.
